// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared slice geometry helpers and commit FSM states
package slice_pkg;

   typedef enum logic [1:0] {
      CFG_IDLE = 2'd0,
      CFG_COMB = 2'd1,
      CFG_MEM  = 2'd2
   } cfg_state_t;

   // Config bits per LUT: both truth-table halves, then split, then ram_en
   function automatic int lut_w(input int s);
      return 2 * (1 << s) + 2;
   endfunction

   // Offset of the first mux-enable bit in the scan chain
   function automatic int mux_off(input int s, input int n);
      return n * lut_w(s);
   endfunction

   // Offset of the carry-chain enable bit
   function automatic int use_cc_off(input int s, input int n, input int m);
      return mux_off(s, n) + m;
   endfunction

   // Offset of the first output-register init bit
   function automatic int init_off(input int s, input int n, input int m);
      return use_cc_off(s, n, m) + 1;
   endfunction

   // Total scan chain length
   function automatic int conf_w(input int s, input int n, input int m);
      return init_off(s, n, m) + 2 * n;
   endfunction

endpackage

// File: rtl/slicem_lut.sv
// rtl/slicem_lut.sv - one fracturable LUT with active storage and LUT-RAM write port
module slicem_lut #(
   parameter int S = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [2*(2**S)-1:0]   cfg_tt,
   input  logic                  cfg_split,
   input  logic                  cfg_ram_en,
   input  logic [S-1:0]          a,
   input  logic [S-1:0]          b,
   input  logic                  we,
   input  logic [S:0]            addr,
   input  logic                  wdata,
   output logic                  out0,
   output logic                  out1
);

   localparam int TT_W = 2 * (2 ** S);

   logic [TT_W-1:0] tt_q;
   logic            split_q;
   logic            ram_en_q;

   // Commit load wins over a runtime write landing in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_q     <= '0;
         split_q  <= 1'b0;
         ram_en_q <= 1'b0;
      end else if (load) begin
         tt_q     <= cfg_tt;
         split_q  <= cfg_split;
         ram_en_q <= cfg_ram_en;
      end else if (we && ram_en_q) begin
         tt_q[addr] <= wdata;
      end
   end

   // Split: two independent S-input halves; unsplit: one (S+1)-input table
   always_comb begin
      out0 = 1'b0;
      out1 = 1'b0;
      if (split_q) begin
         out0 = tt_q[{1'b0, a}];
         out1 = tt_q[{1'b1, b}];
      end else begin
         out0 = tt_q[{b[0], a}];
         out1 = out0;
      end
   end

endmodule

// File: rtl/baked_slicem.sv
// rtl/baked_slicem.sv - logic slice top: scan chain, commit FSM, mux tree, carry, output registers
module baked_slicem
   import slice_pkg::*;
#(
   parameter int S_XX_BASE = 4,
   parameter int NUM_LUTS  = 4,
   parameter int MUX_LVLS  = $clog2(NUM_LUTS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cen,
   input  logic                              cen_soft,
   input  logic                              shift_in,
   input  logic                              shift_in_soft,
   input  logic                              set_in,
   input  logic                              set_in_soft,
   output logic                              shift_out,
   output logic                              set_out,
   output logic                              cfg_busy,
   input  logic [2*S_XX_BASE*NUM_LUTS-1:0]   luts_input,
   input  logic [MUX_LVLS-1:0]               higher_order_address,
   input  logic                              reg_we,
   input  logic                              carry_in,
   output logic                              carry_out,
   input  logic                              ram_we,
   input  logic [MUX_LVLS-1:0]               ram_lut_sel,
   input  logic [S_XX_BASE:0]                ram_addr,
   input  logic                              ram_wdata,
   output logic [2*NUM_LUTS-1:0]             comb_output,
   output logic [2*NUM_LUTS-1:0]             sync_output
);

   localparam int TT_W     = 2 * (2 ** S_XX_BASE);
   localparam int LUT_W    = lut_w(S_XX_BASE);
   localparam int MUX_OFF  = mux_off(S_XX_BASE, NUM_LUTS);
   localparam int CC_OFF   = use_cc_off(S_XX_BASE, NUM_LUTS, MUX_LVLS);
   localparam int INIT_OFF = init_off(S_XX_BASE, NUM_LUTS, MUX_LVLS);
   localparam int CONF_W   = conf_w(S_XX_BASE, NUM_LUTS, MUX_LVLS);

   cfg_state_t          state_q, state_d;
   logic [CONF_W-1:0]   scan_q;
   logic                set_q;
   logic [MUX_LVLS-1:0] mux_en_q;
   logic                use_cc_q;
   logic [NUM_LUTS-1:0] out0, out1, lut_we;
   logic                set_lvl, set_rise, shift_en, shift_data, commit;
   logic [MUX_LVLS-1:0] mux_sel;
   logic                run, cc;

   assign set_lvl    = set_in | set_in_soft;
   assign set_rise   = set_lvl & ~set_q;
   assign shift_en   = (cen | cen_soft) & (state_q == CFG_IDLE) & ~set_lvl;
   assign shift_data = cen ? shift_in : shift_in_soft;
   assign shift_out  = scan_q[CONF_W-1];
   assign commit     = (state_q == CFG_COMB);

   // Scan chain: new bit enters at bit 0, frozen while a commit is running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q <= '0;
      end else if (shift_en) begin
         scan_q <= {scan_q[CONF_W-2:0], shift_data};
      end
   end

   // Commit-request edge detector and FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_q   <= 1'b0;
         state_q <= CFG_IDLE;
      end else begin
         set_q   <= set_lvl;
         state_q <= state_d;
      end
   end

   // Commit sequencing: edges seen outside IDLE are simply dropped
   always_comb begin
      state_d  = state_q;
      set_out  = 1'b0;
      cfg_busy = 1'b1;
      case (state_q)
         CFG_IDLE: begin
            cfg_busy = 1'b0;
            if (set_rise) state_d = CFG_COMB;
         end
         CFG_COMB: begin
            set_out = 1'b1;
            state_d = CFG_MEM;
         end
         CFG_MEM:  state_d = CFG_IDLE;
         default:  state_d = CFG_IDLE;
      endcase
   end

   // Slice-level active configuration, loaded alongside the truth tables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_en_q <= '0;
         use_cc_q <= 1'b0;
      end else if (commit) begin
         mux_en_q <= scan_q[MUX_OFF +: MUX_LVLS];
         use_cc_q <= scan_q[CC_OFF];
      end
   end

   for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
      assign lut_we[i] = ram_we & (ram_lut_sel == MUX_LVLS'(i)) & (state_q == CFG_IDLE);

      slicem_lut #(.S(S_XX_BASE)) u_lut (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (commit),
         .cfg_tt     (scan_q[i*LUT_W +: TT_W]),
         .cfg_split  (scan_q[i*LUT_W + TT_W]),
         .cfg_ram_en (scan_q[i*LUT_W + TT_W + 1]),
         .a          (luts_input[2*S_XX_BASE*i +: S_XX_BASE]),
         .b          (luts_input[2*S_XX_BASE*i + S_XX_BASE +: S_XX_BASE]),
         .we         (lut_we[i]),
         .addr       (ram_addr),
         .wdata      (ram_wdata),
         .out0       (out0[i]),
         .out1       (out1[i])
      );
   end

   // Output assembly: mux tree on bit 0, carry sums overriding every even bit
   always_comb begin
      comb_output = '0;
      carry_out   = 1'b0;
      run         = 1'b1;
      mux_sel     = '0;
      // Only the unbroken run of enabled levels from level 0 contributes select bits
      for (int j = 0; j < MUX_LVLS; j++) begin
         run        = run & mux_en_q[j];
         mux_sel[j] = higher_order_address[j] & run;
      end
      for (int i = 0; i < NUM_LUTS; i++) begin
         comb_output[2*i]   = out0[i];
         comb_output[2*i+1] = out1[i];
      end
      comb_output[0] = out0[mux_sel];
      cc = carry_in;
      for (int i = 0; i < NUM_LUTS; i++) begin
         if (use_cc_q) comb_output[2*i] = out1[i] ^ cc;
         cc = out1[i] ? cc : luts_input[2*S_XX_BASE*i];
      end
      carry_out = use_cc_q & cc;
   end

   // Output registers: init load during MEM overrides the fabric enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_output <= '0;
      end else if (state_q == CFG_MEM) begin
         sync_output <= scan_q[INIT_OFF +: 2*NUM_LUTS];
      end else if (reg_we) begin
         sync_output <= comb_output;
      end
   end

endmodule

// File: tb/tb_baked_slicem.sv
// tb/tb_baked_slicem.sv - randomized self-checking bench for baked_slicem
module tb_baked_slicem;

   localparam int S        = 4;
   localparam int N        = 4;
   localparam int M        = 2;
   localparam int TT_W     = 32;
   localparam int LUT_W    = TT_W + 2;
   localparam int MUX_POS  = N * LUT_W;
   localparam int CC_POS   = MUX_POS + M;
   localparam int INIT_POS = CC_POS + 1;
   localparam int CONF_W   = INIT_POS + 2 * N;

   logic             clk, rst_n;
   logic             cen, cen_soft, shift_in, shift_in_soft, set_in, set_in_soft;
   logic             shift_out, set_out, cfg_busy;
   logic [2*S*N-1:0] luts_input;
   logic [M-1:0]     higher_order_address, ram_lut_sel;
   logic             reg_we, carry_in, carry_out, ram_we, ram_wdata;
   logic [S:0]       ram_addr;
   logic [2*N-1:0]   comb_output, sync_output;

   baked_slicem #(.S_XX_BASE(S), .NUM_LUTS(N)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .cen                  (cen),
      .cen_soft             (cen_soft),
      .shift_in             (shift_in),
      .shift_in_soft        (shift_in_soft),
      .set_in               (set_in),
      .set_in_soft          (set_in_soft),
      .shift_out            (shift_out),
      .set_out              (set_out),
      .cfg_busy             (cfg_busy),
      .luts_input           (luts_input),
      .higher_order_address (higher_order_address),
      .reg_we               (reg_we),
      .carry_in             (carry_in),
      .carry_out            (carry_out),
      .ram_we               (ram_we),
      .ram_lut_sel          (ram_lut_sel),
      .ram_addr             (ram_addr),
      .ram_wdata            (ram_wdata),
      .comb_output          (comb_output),
      .sync_output          (sync_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: active contents, commit countdown and scan history
   logic [TT_W-1:0] m_tt [N];
   logic            m_split [N];
   logic            m_ram_en [N];
   logic [M-1:0]    m_mux;
   logic            m_cc;
   logic [2*N-1:0]  m_sync;
   logic            m_set_q;
   int              m_left;
   bit              hist [$];
   logic [CONF_W-1:0] cfg;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic chain_bit(input int p);
      if (p < hist.size()) return hist[hist.size() - 1 - p];
      return 1'b0;
   endfunction

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         m_tt[i] = '0;
         m_split[i] = 1'b0;
         m_ram_en[i] = 1'b0;
      end
      m_mux = '0;
      m_cc = 1'b0;
      m_sync = '0;
      m_set_q = 1'b0;
      m_left = 0;
      hist.delete();
   endtask

   task automatic model_eval(output logic [2*N-1:0] co, output logic cout);
      logic [N-1:0] o0, o1;
      int ia, ib, k, sel;
      logic c;
      co = '0;
      for (int i = 0; i < N; i++) begin
         ia = int'(luts_input[2*S*i +: S]);
         ib = int'(luts_input[2*S*i+S +: S]);
         if (m_split[i]) begin
            o0[i] = m_tt[i][ia];
            o1[i] = m_tt[i][TT_W/2 + ib];
         end else begin
            o0[i] = m_tt[i][(ib % 2) * (TT_W/2) + ia];
            o1[i] = o0[i];
         end
         co[2*i]   = o0[i];
         co[2*i+1] = o1[i];
      end
      k = 0;
      while (k < M && m_mux[k]) k++;
      sel = int'(higher_order_address) % (1 << k);
      co[0] = o0[sel];
      cout = 1'b0;
      if (m_cc) begin
         c = carry_in;
         for (int i = 0; i < N; i++) begin
            co[2*i] = o1[i] ^ c;
            c = o1[i] ? c : luts_input[2*S*i];
         end
         cout = c;
      end
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs
   task automatic tick();
      logic [2*N-1:0] co;
      logic cout, lvl, rise, sh, din;
      #1;
      model_eval(co, cout);
      check("comb_output", comb_output, co);
      check("carry_out", carry_out, cout);
      lvl  = set_in | set_in_soft;
      rise = lvl & ~m_set_q;
      sh   = (cen | cen_soft) & (m_left == 0) & ~lvl;
      din  = cen ? shift_in : shift_in_soft;
      @(posedge clk);
      if (!rst_n) begin
         reset_model();
      end else begin
         if (m_left == 1) begin
            for (int j = 0; j < 2*N; j++) m_sync[j] = chain_bit(INIT_POS + j);
         end else if (reg_we) begin
            m_sync = co;
         end
         if (m_left == 2) begin
            for (int i = 0; i < N; i++) begin
               for (int t = 0; t < TT_W; t++) m_tt[i][t] = chain_bit(i*LUT_W + t);
               m_split[i]  = chain_bit(i*LUT_W + TT_W);
               m_ram_en[i] = chain_bit(i*LUT_W + TT_W + 1);
            end
            for (int j = 0; j < M; j++) m_mux[j] = chain_bit(MUX_POS + j);
            m_cc = chain_bit(CC_POS);
         end else if (m_left == 0 && ram_we && m_ram_en[ram_lut_sel]) begin
            m_tt[ram_lut_sel][ram_addr] = ram_wdata;
         end
         if (sh) begin
            hist.push_back(din);
            if (hist.size() > CONF_W) void'(hist.pop_front());
         end
         m_set_q = lvl;
         if (m_left > 0) m_left--;
         else if (rise) m_left = 2;
      end
      #1;
      check("sync_output", sync_output, m_sync);
      check("shift_out", shift_out, chain_bit(CONF_W - 1));
      check("set_out", set_out, m_left == 2);
      check("cfg_busy", cfg_busy, m_left != 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_comb_output", comb_output, 0);
      check("rst_sync_output", sync_output, 0);
      check("rst_carry_out", carry_out, 0);
      check("rst_shift_out", shift_out, 0);
      check("rst_set_out", set_out, 0);
      check("rst_cfg_busy", cfg_busy, 0);
   endtask

   task automatic cfg_lut(input int i, input logic [TT_W-1:0] tt, input logic split, input logic ram_en);
      cfg[i*LUT_W +: TT_W] = tt;
      cfg[i*LUT_W + TT_W] = split;
      cfg[i*LUT_W + TT_W + 1] = ram_en;
   endtask

   // Shift cfg in MSB first over randomly chosen hard/soft paths
   task automatic load_cfg();
      for (int p = CONF_W - 1; p >= 0; p--) begin
         if ($urandom_range(1) == 1) begin
            cen = 1'b1;
            cen_soft = 1'($urandom_range(1));
            shift_in = cfg[p];
            shift_in_soft = ~cfg[p];
         end else begin
            cen = 1'b0;
            cen_soft = 1'b1;
            shift_in = 1'($urandom_range(1));
            shift_in_soft = cfg[p];
         end
         tick();
      end
      cen = 1'b0;
      cen_soft = 1'b0;
   endtask

   // Raise a commit request and hold it past the end of the sequence
   task automatic commit(input logic do_ram);
      if ($urandom_range(1) == 1) set_in = 1'b1;
      else set_in_soft = 1'b1;
      tick();
      check("commit_set_out_hi", set_out, 1);
      ram_we = do_ram;
      ram_lut_sel = M'($urandom);
      ram_addr = (S+1)'($urandom);
      ram_wdata = 1'b1;
      tick();
      check("commit_set_out_lo", set_out, 0);
      check("commit_busy_mem", cfg_busy, 1);
      tick();
      ram_we = 1'b0;
      check("commit_busy_done", cfg_busy, 0);
      tick();
      set_in = 1'b0;
      set_in_soft = 1'b0;
      tick();
   endtask

   task automatic rand_cycle();
      luts_input = $urandom;
      higher_order_address = M'($urandom);
      carry_in = 1'($urandom);
      reg_we = 1'($urandom);
      ram_we = ($urandom_range(3) == 0);
      ram_lut_sel = M'($urandom);
      ram_addr = (S+1)'($urandom);
      ram_wdata = 1'($urandom);
      cen = ($urandom_range(7) == 0);
      cen_soft = ($urandom_range(7) == 0);
      shift_in = 1'($urandom);
      shift_in_soft = 1'($urandom);
      set_in = ($urandom_range(15) == 0);
      set_in_soft = ($urandom_range(15) == 0);
      tick();
   endtask

   task automatic idle_inputs();
      cen = 0; cen_soft = 0; shift_in = 0; shift_in_soft = 0;
      set_in = 0; set_in_soft = 0; ram_we = 0; reg_we = 0;
      ram_lut_sel = 0; ram_addr = 0; ram_wdata = 0;
      luts_input = 0; higher_order_address = 0; carry_in = 0;
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      reset_model();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // LUT0 AND-style table, LUT1 RAM-enabled, init pattern
      cfg = '0;
      cfg_lut(0, 32'h0000_8000, 1'b1, 1'b0);
      cfg_lut(1, 32'h0000_0000, 1'b0, 1'b1);
      cfg[INIT_POS +: 2*N] = 8'hA5;
      load_cfg();
      commit(1'b1);
      check("init_load", sync_output, 8'hA5);
      luts_input = 0;
      luts_input[3:0] = 4'hF;
      reg_we = 1'b1;
      tick();
      check("lut0_a_f", comb_output[0], 1);
      check("sync_follow_1", sync_output[0], 1);
      luts_input[3:0] = 4'hE;
      reg_we = 1'b0;
      tick();
      check("lut0_a_e", comb_output[0], 0);
      check("sync_hold", sync_output[0], 1);
      reg_we = 1'b1;
      tick();
      check("sync_follow_0", sync_output[0], 0);
      reg_we = 1'b0;
      luts_input[11:8] = 4'h3;
      tick();
      check("ram_pre", comb_output[2], 0);
      ram_we = 1'b1; ram_lut_sel = 2'd1; ram_addr = 5'd3; ram_wdata = 1'b1;
      tick();
      ram_we = 1'b0;
      check("ram_post", comb_output[2], 1);
      luts_input[3:0] = 4'h3;
      ram_we = 1'b1; ram_lut_sel = 2'd0;
      tick();
      ram_we = 1'b0;
      check("ram_disabled", comb_output[0], 0);

      // Mux tree fully enabled, only LUT2 drives a one
      idle_inputs();
      cfg = '0;
      cfg_lut(2, 32'h0000_FFFF, 1'b1, 1'b0);
      cfg[MUX_POS +: M] = 2'b11;
      load_cfg();
      commit(1'b0);
      luts_input = $urandom;
      higher_order_address = 2'd2;
      tick();
      check("mux_addr2", comb_output[0], 1);
      higher_order_address = 2'd1;
      tick();
      check("mux_addr1", comb_output[0], 0);

      // Carry chain: all propagate, then kill at LUT1
      idle_inputs();
      cfg = '0;
      for (int i = 0; i < N; i++) cfg_lut(i, 32'hFFFF_0000, 1'b1, 1'b0);
      cfg_lut(1, 32'hFFFE_0000, 1'b1, 1'b0);
      cfg[CC_POS] = 1'b1;
      load_cfg();
      commit(1'b0);
      luts_input = 32'hF0F0_F0F0;
      carry_in = 1'b1;
      tick();
      check("carry_propagate", carry_out, 1);
      check("carry_sums_zero", comb_output & 8'h55, 0);
      luts_input = 32'hF0F0_00F0;
      tick();
      check("carry_kill", carry_out, 0);

      // Reset while in CFG_COMB
      idle_inputs();
      for (int p = 0; p < CONF_W; p++) cfg[p] = 1'($urandom);
      load_cfg();
      set_in = 1'b1;
      tick();
      check("pre_abort_busy", cfg_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      reset_model();
      check_reset_outputs();
      set_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      load_cfg();
      commit(1'b1);

      // Random configurations and random traffic
      for (int r = 0; r < 3; r++) begin
         idle_inputs();
         for (int p = 0; p < CONF_W; p++) cfg[p] = 1'($urandom);
         load_cfg();
         commit(1'($urandom));
         for (int c = 0; c < 150; c++) rand_cycle();
      end
      idle_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
